// File: rtl/tt_pkg.sv
// Shared types and sizing helpers for the sequential truth-table evaluator.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        SWEEP  = 2'd2,
        FIN    = 2'd3
    } state_t;

    // Table bits per channel for an n-input function
    function automatic int TW(input int n);
        return 1 << n;
    endfunction

    // Width of a per-channel ones counter (holds 0..2**n)
    function automatic int CNT_W(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/tt_sweep_eval_if.sv
// Result stream of the truth-table evaluator: valid/ready with input vector and per-channel result.
interface tt_sweep_eval_if #(
    parameter int N_IN = 3,
    parameter int NCH  = 1
);
    logic            out_valid;
    logic            out_ready;
    logic [N_IN-1:0] out_vec;
    logic [NCH-1:0]  out_s;

    modport master (output out_valid, output out_vec, output out_s, input out_ready);
    modport slave  (input out_valid, input out_vec, input out_s, output out_ready);
endinterface

// File: rtl/tt_lut_ch.sv
// One channel: programmable TW-bit truth table and its read mux.
module tt_lut_ch
    import tt_pkg::*;
#(
    parameter int                   N_IN     = 3,
    parameter logic [TW(N_IN)-1:0]  RESET_TT = 'hAC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we_i,
    input  logic [TW(N_IN)-1:0] wdata_i,
    input  logic [N_IN-1:0]     addr_i,
    output logic                rd_o
);
    logic [TW(N_IN)-1:0] tbl_q;
    logic [TW(N_IN)-1:0] tbl_d;

    assign tbl_d = we_i ? wdata_i : tbl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_q <= RESET_TT;
        end else begin
            tbl_q <= tbl_d;
        end
    end

    // Read from the next-state table so a write in the start cycle feeds the first result
    assign rd_o = tbl_d[addr_i];

endmodule

// File: rtl/tt_sweep_eval.sv
// Sequential truth-table evaluator: single-operand or full-sweep evaluation of NCH tables.
// Optional per-channel ones counters are enabled with `define TT_ONES_COUNT_EN.
module tt_sweep_eval
    import tt_pkg::*;
#(
    parameter int                   N_IN     = 3,
    parameter int                   NCH      = 1,
    parameter logic [TW(N_IN)-1:0]  RESET_TT = 8'hAC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [NCH*TW(N_IN)-1:0]  cfg_table,
    input  logic                     start,
    input  logic                     mode,
    input  logic [N_IN-1:0]          in_vec,
    tt_sweep_eval_if.master          out_if,
    output logic                     busy,
    output logic                     done
`ifdef TT_ONES_COUNT_EN
   ,output logic [NCH*CNT_W(N_IN)-1:0] ones_cnt
`endif
);
    localparam int            TWL  = TW(N_IN);
    localparam logic [N_IN:0] LAST = (N_IN+1)'(TWL - 1);

    state_t          state_q, state_d;
    logic [N_IN:0]   idx_q, idx_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [NCH-1:0]  s_q, rd_s;
    logic            valid_q, valid_d;
    logic            ld_s;
    logic            idle;
    logic            accept;

    assign idle   = (state_q == IDLE);
    assign accept = valid_q & out_if.out_ready;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        tt_lut_ch #(
            .N_IN     (N_IN),
            .RESET_TT (RESET_TT)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (cfg_we & idle),
            .wdata_i (cfg_table[c*TWL +: TWL]),
            .addr_i  (vec_d),
            .rd_o    (rd_s[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            if (ld_s) begin
                s_q <= rd_s;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        valid_d = valid_q;
        ld_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    valid_d = 1'b1;
                    ld_s    = 1'b1;
                    if (mode) begin
                        state_d = SWEEP;
                        idx_d   = '0;
                        vec_d   = '0;
                    end else begin
                        state_d = SINGLE;
                        vec_d   = in_vec;
                    end
                end
            end
            SINGLE: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = FIN;
                end
            end
            SWEEP: begin
                if (accept) begin
                    if (idx_q == LAST) begin
                        valid_d = 1'b0;
                        state_d = FIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        vec_d = idx_d[N_IN-1:0];
                        ld_s  = 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_vec   = vec_q;
    assign out_if.out_s     = s_q;
    assign busy             = !idle;
    assign done             = (state_q == FIN);

`ifdef TT_ONES_COUNT_EN
    localparam int CW = CNT_W(N_IN);

    logic [NCH*CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (idle && start) begin
            cnt_q <= '0;
        end else if (accept) begin
            for (int c = 0; c < NCH; c++) begin
                if (s_q[c]) begin
                    cnt_q[c*CW +: CW] <= cnt_q[c*CW +: CW] + CW'(1);
                end
            end
        end
    end

    assign ones_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_tt_sweep_eval.sv
// Randomised self-checking bench for tt_sweep_eval (N_IN=3, NCH=2) against a queue-based reference model.
module tb_tt_sweep_eval;
    localparam int N_IN = 3;
    localparam int NCH  = 2;
    localparam int TWB  = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_we = 1'b0;
    logic [NCH*TWB-1:0]  cfg_table = '0;
    logic                start = 1'b0;
    logic                mode = 1'b0;
    logic [N_IN-1:0]     in_vec = '0;
    logic                busy;
    logic                done;
`ifdef TT_ONES_COUNT_EN
    logic [NCH*4-1:0]    ones_cnt;
`endif

    tt_sweep_eval_if #(.N_IN(N_IN), .NCH(NCH)) bus ();

    tt_sweep_eval #(.N_IN(N_IN), .NCH(NCH), .RESET_TT(8'hAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_table (cfg_table),
        .start     (start),
        .mode      (mode),
        .in_vec    (in_vec),
        .out_if    (bus),
        .busy      (busy),
        .done      (done)
`ifdef TT_ONES_COUNT_EN
       ,.ones_cnt  (ones_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the truth table each channel currently holds
    logic [TWB-1:0] tbl [NCH];
    int             last_ones [NCH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NCH-1:0] exp_s(input int v);
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = tbl[c][v];
        return r;
    endfunction

    function automatic logic [NCH*4-1:0] exp_cnt();
        logic [NCH*4-1:0] r;
        for (int c = 0; c < NCH; c++) r[c*4 +: 4] = 4'(last_ones[c]);
        return r;
    endfunction

    task automatic reset_model();
        for (int c = 0; c < NCH; c++) begin
            tbl[c]       = 8'hAC;
            last_ones[c] = 0;
        end
    endtask

    function automatic logic pick_ready(input int rpat, input int cyc);
        case (rpat)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            2:       return ((cyc - 1) % 3) == 0;
            default: return cyc > 5;
        endcase
    endfunction

    // One complete operation started from IDLE; noise drives start/cfg activity while busy
    task automatic run_op(input bit md, input logic [N_IN-1:0] v, input bit wr,
                          input logic [NCH*TWB-1:0] tw, input int rpat, input bit noise);
        int exp_vecs[$];
        int cyc;
        logic rdy;
        cfg_we    = wr;
        cfg_table = tw;
        start     = 1'b1;
        mode      = md;
        in_vec    = v;
        @(posedge clk);
        #1;
        if (wr) for (int c = 0; c < NCH; c++) tbl[c] = tw[c*TWB +: TWB];
        start  = 1'b0;
        cfg_we = 1'b0;
        if (md) for (int i = 0; i < TWB; i++) exp_vecs.push_back(i);
        else exp_vecs.push_back(int'(v));
        for (int c = 0; c < NCH; c++) last_ones[c] = 0;
        cyc = 0;
        while (exp_vecs.size() > 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            chk("valid", 32'(bus.out_valid), 32'd1);
            chk("busy",  32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            chk("vec", 32'(bus.out_vec), 32'(exp_vecs[0]));
            chk("s",   32'(bus.out_s), 32'(exp_s(exp_vecs[0])));
            rdy = pick_ready(rpat, cyc);
            bus.out_ready = rdy;
            if (noise) begin
                start     = 1'($urandom_range(0, 1));
                mode      = 1'($urandom_range(0, 1));
                in_vec    = N_IN'($urandom);
                cfg_we    = 1'($urandom_range(0, 1));
                cfg_table = (NCH*TWB)'($urandom);
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                for (int c = 0; c < NCH; c++)
                    if (tbl[c][exp_vecs[0]]) last_ones[c]++;
                void'(exp_vecs.pop_front());
            end
        end
        if (exp_vecs.size() > 0) chk("beat_timeout", 32'd1, 32'd0);
        if (md && rpat == 0) chk("sweep_cycles", 32'(cyc), 32'(TWB));
        start         = 1'b0;
        cfg_we        = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_fin", 32'(busy), 32'd1);
        chk("valid_fin", 32'(bus.out_valid), 32'd0);
`ifdef TT_ONES_COUNT_EN
        chk("ones_cnt", 32'(ones_cnt), 32'(exp_cnt()));
`endif
        @(negedge clk);
        chk("done_clear", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
`ifdef TT_ONES_COUNT_EN
        chk("ones_hold", 32'(ones_cnt), 32'(exp_cnt()));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.out_ready = 1'b0;
        reset_model();
        #3;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_vec",   32'(bus.out_vec), 32'd0);
        chk("rst_s",     32'(bus.out_s), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full sweep on the reset table with ready held high
        run_op(1'b1, '0, 1'b0, '0, 0, 1'b0);
        // Single on 5, consumer stalls five cycles
        run_op(1'b0, 3'b101, 1'b0, '0, 3, 1'b0);
        // Sweep with ready pattern 1,0,0,...
        run_op(1'b1, '0, 1'b0, '0, 2, 1'b0);
        // Table write together with start
        run_op(1'b1, '0, 1'b1, {8'hFF, 8'h01}, 0, 1'b0);
        // Start/cfg activity while busy, both modes, then confirm tables unchanged
        run_op(1'b1, '0, 1'b0, '0, 1, 1'b1);
        run_op(1'b0, 3'd6, 1'b0, '0, 1, 1'b1);
        run_op(1'b1, '0, 1'b0, '0, 0, 1'b0);

        // Asynchronous reset in the middle of a sweep
        start = 1'b1;
        mode  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_vec", 32'(bus.out_vec), 32'd4);
        #2;
        rst_n = 1'b0;
        reset_model();
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_vec",   32'(bus.out_vec), 32'd0);
        chk("mid_rst_s",     32'(bus.out_s), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_done",  32'(done), 32'd0);
`ifdef TT_ONES_COUNT_EN
        chk("mid_rst_cnt",   32'(ones_cnt), 32'd0);
`endif
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("rst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", 32'(done), 32'd0);
        run_op(1'b1, '0, 1'b0, '0, 0, 1'b0);

        // Randomised operations
        for (int n = 0; n < 24; n++) begin
            run_op(1'($urandom_range(0, 1)), N_IN'($urandom), 1'($urandom_range(0, 1)),
                   (NCH*TWB)'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
